jk_excite_seq: RTL and testbench

- Inverse-direction companion to the flip-flop converter blocks. The converters map inputs to a next state (characteristic table). This block maps a desired next state to JK inputs (excitation table).
- Accepts a stream of N-bit target states over a valid/ready handshake.
- For each target it drives j/k for one clock into an external bank of N JK flip-flops, keeps a model of the expected q, and checks the returned q.
- Used as a self-checking stimulus engine in front of JK flip-flop and converter instances.

---
 rtl/ff_conv_pkg.sv | 40 ++++
 rtl/jk_excite_bit.sv | 16 +
 rtl/jk_excite_seq.sv | 120 ++++++++++++
 tb/tb_jk_excite_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop converter / excitation family:
// sequencer state encoding, excitation constants and the JK excitation helper.
package ff_conv_pkg;

    // Sequencer states: accept a target, drive it for one cycle, check the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Transition codes {q, q_next} used to index the excitation table.
    localparam logic [1:0] TR_0_TO_0 = 2'b00;
    localparam logic [1:0] TR_0_TO_1 = 2'b01;
    localparam logic [1:0] TR_1_TO_0 = 2'b10;
    localparam logic [1:0] TR_1_TO_1 = 2'b11;

    // Fixed (non-don't-care) halves of the JK excitation for each transition.
    localparam logic J_FOR_0_TO_0 = 1'b0;
    localparam logic J_FOR_0_TO_1 = 1'b1;
    localparam logic K_FOR_1_TO_0 = 1'b1;
    localparam logic K_FOR_1_TO_1 = 1'b0;

    // JK excitation for one flip-flop: returns {j, k} that moves q to q_next.
    // The don't-care half of each pair is filled with dc; either value of dc
    // still produces the requested next state.
    function automatic logic [1:0] jk_excite(input logic q, input logic q_next,
                                             input logic dc);
        logic [1:0] jk;
        case ({q, q_next})
            TR_0_TO_0: jk = {J_FOR_0_TO_0, dc};
            TR_0_TO_1: jk = {J_FOR_0_TO_1, dc};
            TR_1_TO_0: jk = {dc, K_FOR_1_TO_0};
            TR_1_TO_1: jk = {dc, K_FOR_1_TO_1};
            default:   jk = 2'b00;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Combinational JK excitation for a single flip-flop.
module jk_excite_bit
    import ff_conv_pkg::*;
#(
    parameter bit DC_VAL = 1'b0
) (
    input  logic q,
    input  logic q_next,
    output logic j,
    output logic k
);

    // Map the (current, desired) state pair onto the J/K inputs.
    assign {j, k} = jk_excite(q, q_next, DC_VAL);

endmodule

// File: rtl/jk_excite_seq.sv
// JK excitation sequencer: takes a stream of target states, drives j/k for one
// cycle into an external bank of JK flip-flops, tracks the expected state and
// checks the returned q one cycle later.
module jk_excite_seq
    import ff_conv_pkg::*;
#(
    parameter int N      = 4,
    parameter bit DC_VAL = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [N-1:0]     tgt_q,
    output logic [N-1:0]     j,
    output logic [N-1:0]     k,
    output logic             drv_valid,
    input  logic [N-1:0]     q_fb,
    output logic [N-1:0]     q_model,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t       state;
    state_t       state_next;
    logic [N-1:0] exc_j;
    logic [N-1:0] exc_k;
    logic [N-1:0] tgt_cap;
    logic         accept;
    logic         mismatch;

    assign accept   = (state == IDLE) && tgt_valid;
    assign mismatch = (state == CHECK) && (q_fb != q_model);

    // Per-bit excitation from the current model state towards the offered target.
    for (genvar i = 0; i < N; i++) begin : g_bit
        jk_excite_bit #(.DC_VAL(DC_VAL)) u_bit (
            .q      (q_model[i]),
            .q_next (tgt_q[i]),
            .j      (exc_j[i]),
            .k      (exc_k[i])
        );
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: IDLE -> DRIVE on handshake, then one cycle each in DRIVE and CHECK.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (tgt_valid) state_next = DRIVE;
            DRIVE:   state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        tgt_ready = 1'b0;
        drv_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                tgt_ready = 1'b1;
                busy      = 1'b0;
            end
            DRIVE:   drv_valid = 1'b1;
            default: ;
        endcase
    end

    // Excitation registers and expected-state model: load j/k on accept, drop
    // them back to hold at the edge that ends DRIVE, when the model advances.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            j       <= '0;
            k       <= '0;
            tgt_cap <= '0;
            q_model <= '0;
        end else if (accept) begin
            j       <= exc_j;
            k       <= exc_k;
            tgt_cap <= tgt_q;
        end else if (state == DRIVE) begin
            j       <= '0;
            k       <= '0;
            q_model <= tgt_cap;
        end
    end

    // Checker: sticky error flag and saturating per-transaction mismatch count;
    // a clear request overrides a simultaneous mismatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_jk_excite_seq.sv
// Directed bench for jk_excite_seq: two instances (DC_VAL=0 and DC_VAL=1) share
// the stimulus, each with its own behavioural JK flip-flop bank on q_fb.
module tb_jk_excite_seq;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             tgt_valid;
    logic [N-1:0]     tgt_q;
    logic             err_clr;
    logic             fb_force;
    logic [N-1:0]     fb_val;

    logic             tgt_ready0, tgt_ready1;
    logic [N-1:0]     j0, k0, j1, k1;
    logic             drv_valid0, drv_valid1;
    logic [N-1:0]     q_model0, q_model1;
    logic             err0, err1;
    logic [CNT_W-1:0] err_cnt0, err_cnt1;
    logic             busy0, busy1;
    logic [N-1:0]     ffq0, ffq1;
    logic [N-1:0]     q_fb0, q_fb1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign q_fb0 = fb_force ? fb_val : ffq0;
    assign q_fb1 = fb_force ? fb_val : ffq1;

    jk_excite_seq #(.N(N), .DC_VAL(1'b0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready0),
        .tgt_q(tgt_q), .j(j0), .k(k0), .drv_valid(drv_valid0), .q_fb(q_fb0),
        .q_model(q_model0), .err(err0), .err_cnt(err_cnt0), .err_clr(err_clr),
        .busy(busy0)
    );

    jk_excite_seq #(.N(N), .DC_VAL(1'b1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .reset(reset), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready1),
        .tgt_q(tgt_q), .j(j1), .k(k1), .drv_valid(drv_valid1), .q_fb(q_fb1),
        .q_model(q_model1), .err(err1), .err_cnt(err_cnt1), .err_clr(err_clr),
        .busy(busy1)
    );

    // Behavioural JK flip-flop banks, reset together with the sequencers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ffq0 <= '0;
            ffq1 <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                case ({j0[i], k0[i]})
                    2'b01:   ffq0[i] <= 1'b0;
                    2'b10:   ffq0[i] <= 1'b1;
                    2'b11:   ffq0[i] <= ~ffq0[i];
                    default: ffq0[i] <= ffq0[i];
                endcase
                case ({j1[i], k1[i]})
                    2'b01:   ffq1[i] <= 1'b0;
                    2'b10:   ffq1[i] <= 1'b1;
                    2'b11:   ffq1[i] <= ~ffq1[i];
                    default: ffq1[i] <= ffq1[i];
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: handshake, DRIVE, CHECK, back in IDLE.
    task automatic send(input logic [N-1:0] t);
        tgt_valid = 1'b1;
        tgt_q     = t;
        step();
        tgt_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset     = 1'b0;
        tgt_valid = 1'b0;
        tgt_q     = '0;
        err_clr   = 1'b0;
        fb_force  = 1'b0;
        fb_val    = '0;
        step();
        step();

        // Reset values.
        check("rst_ready", tgt_ready0, 1);
        check("rst_j",     j0, 0);
        check("rst_k",     k0, 0);
        check("rst_drv",   drv_valid0, 0);
        check("rst_qm",    q_model0, 0);
        check("rst_err",   err0, 0);
        check("rst_cnt",   err_cnt0, 0);
        check("rst_busy",  busy0, 0);
        reset = 1'b1;
        step();

        // 1. Reset asserted mid-DRIVE with j=1111 aborts immediately.
        tgt_valid = 1'b1;
        tgt_q     = 4'b1111;
        step();
        tgt_valid = 1'b0;
        check("t1_drive_j", j0, 4'b1111);
        check("t1_drive_dv", drv_valid0, 1);
        #2;
        reset = 1'b0;
        #1;
        check("t1_abort_j",     j0, 0);
        check("t1_abort_dv",    drv_valid0, 0);
        check("t1_abort_ready", tgt_ready0, 1);
        check("t1_abort_busy",  busy0, 0);
        step();
        reset = 1'b1;
        step();
        check("t1_post_ready", tgt_ready0, 1);
        check("t1_post_qm",    q_model0, 0);
        check("t1_post_busy",  busy0, 0);

        // 2. 0000 -> 1010.
        tgt_valid = 1'b1;
        tgt_q     = 4'b1010;
        step();
        tgt_valid = 1'b0;
        check("t2_j0",   j0, 4'b1010);
        check("t2_k0",   k0, 4'b0000);
        check("t2_j1",   j1, 4'b1010);
        check("t2_k1",   k1, 4'b1111);
        check("t2_busy", busy0, 1);
        step();
        check("t2_qm0",    q_model0, 4'b1010);
        check("t2_chk_j",  j0, 0);
        check("t2_chk_dv", drv_valid0, 0);
        step();
        check("t2_err0", err0, 0);
        check("t2_err1", err1, 0);

        // 3. 1010 -> 0110; DC_VAL=1 values derived bit by bit from the table:
        //    b3 1->0 {1,1}, b2 0->1 {1,1}, b1 1->1 {1,0}, b0 0->0 {0,1}.
        tgt_valid = 1'b1;
        tgt_q     = 4'b0110;
        step();
        tgt_valid = 1'b0;
        check("t3_j0", j0, 4'b0100);
        check("t3_k0", k0, 4'b1000);
        check("t3_j1", j1, 4'b1110);
        check("t3_k1", k1, 4'b1101);
        step();
        step();
        check("t3_qm0",  q_model0, 4'b0110);
        check("t3_qm1",  q_model1, 4'b0110);
        check("t3_ffq1", ffq1, 4'b0110);
        check("t3_err0", err0, 0);
        check("t3_err1", err1, 0);

        // 4. Back-to-back with tgt_valid held: 1111 then 0000.
        tgt_valid = 1'b1;
        tgt_q     = 4'b1111;
        check("t4_ready_a", tgt_ready0, 1);
        step();
        check("t4_drive_a_dv",    drv_valid0, 1);
        check("t4_drive_a_ready", tgt_ready0, 0);
        check("t4_drive_a_j",     j0, 4'b1001);
        step();
        check("t4_check_a_dv",    drv_valid0, 0);
        check("t4_check_a_ready", tgt_ready0, 0);
        tgt_q = 4'b0000;
        step();
        check("t4_idle_ready", tgt_ready0, 1);
        check("t4_idle_dv",    drv_valid0, 0);
        check("t4_idle_qm",    q_model0, 4'b1111);
        step();
        check("t4_drive_b_dv",    drv_valid0, 1);
        check("t4_drive_b_ready", tgt_ready0, 0);
        check("t4_drive_b_k",     k0, 4'b1111);
        step();
        tgt_valid = 1'b0;
        check("t4_check_b_dv", drv_valid0, 0);
        step();
        check("t4_final_qm", q_model0, 4'b0000);
        check("t4_final_err", err0, 0);

        // 5. Forced wrong feedback: sticky error, then counter saturation.
        fb_force = 1'b1;
        fb_val   = 4'b0000;
        send(4'b1010);
        check("t5_err",  err0, 1);
        check("t5_cnt1", err_cnt0, 1);
        for (int i = 2; i <= 301; i++) begin
            send(4'b1010);
            if (i == 254) check("t5_cnt254", err_cnt0, 254);
            if (i == 255) check("t5_cnt255", err_cnt0, 255);
        end
        check("t5_sat0", err_cnt0, 255);
        check("t5_sat1", err_cnt1, 255);

        // 6. Clear coinciding with a CHECK mismatch wins.
        tgt_valid = 1'b1;
        tgt_q     = 4'b1010;
        step();
        tgt_valid = 1'b0;
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t6_clr_err", err0, 0);
        check("t6_clr_cnt", err_cnt0, 0);
        send(4'b1010);
        check("t6_next_err", err0, 1);
        check("t6_next_cnt", err_cnt0, 1);

        // Feedback outside CHECK is ignored: mismatching q_fb while idle.
        fb_val = 4'b0101;
        step();
        step();
        check("t6_idle_cnt", err_cnt0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
